pipelined_adder32: RTL and testbench

PIPELINED_ADDER32 -- requirements
Module: pipelined_adder32

---
 rtl/risc_alu_pkg.sv | 17 +
 rtl/cla_adder16.sv | 59 +++++
 rtl/pipelined_adder32.sv | 103 ++++++++++
 tb/tb_pipelined_adder32.sv | 381 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/risc_alu_pkg.sv
// Shared widths and the stage-1 pipeline register layout for the 32-bit
// two-stage adder.
package risc_alu_pkg;

    localparam int W      = 32;
    localparam int HALF_W = 16;

    // Stage-1 register: upper operand halves plus the finished low half and
    // the carry crossing into bit 16.
    typedef struct packed {
        logic [HALF_W-1:0] a_hi;
        logic [HALF_W-1:0] b_hi;
        logic [HALF_W-1:0] sum_lo;
        logic              c_mid;
    } s1_reg_t;

endpackage

// File: rtl/cla_adder16.sv
// 16-bit carry-lookahead adder: four 4-bit lookahead groups whose group
// generate/propagate terms feed a second-level lookahead carry unit.
module cla_adder16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    input  logic        c_in,
    output logic [15:0] sum,
    output logic        c_out
);
    import risc_alu_pkg::*;

    logic [HALF_W-1:0] g;
    logic [HALF_W-1:0] p;
    logic [HALF_W-1:0] c;
    logic [3:0]        gg;
    logic [3:0]        gp;
    logic [4:0]        gc;

    assign g = a & b;
    assign p = a ^ b;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int j = 0; j < 4; j++) begin
            gg[j] = g[4*j+3]
                  | (p[4*j+3] & g[4*j+2])
                  | (p[4*j+3] & p[4*j+2] & g[4*j+1])
                  | ((&p[4*j+1 +: 3]) & g[4*j]);
            gp[j] = &p[4*j +: 4];
        end
    end

    // Second-level lookahead: every group carry-in comes straight from c_in.
    assign gc[0] = c_in;
    assign gc[1] = gg[0] | (gp[0] & c_in);
    assign gc[2] = gg[1] | (gp[1] & gg[0]) | (gp[1] & gp[0] & c_in);
    assign gc[3] = gg[2] | (gp[2] & gg[1]) | (gp[2] & gp[1] & gg[0])
                 | (gp[2] & gp[1] & gp[0] & c_in);
    assign gc[4] = gg[3] | (gp[3] & gg[2]) | (gp[3] & gp[2] & gg[1])
                 | (gp[3] & gp[2] & gp[1] & gg[0])
                 | (gp[3] & gp[2] & gp[1] & gp[0] & c_in);

    always_comb begin
        c = '0;
        for (int j = 0; j < 4; j++) begin
            c[4*j]   = gc[j];
            c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
            c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | (p[4*j+1] & p[4*j] & gc[j]);
            c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1])
                     | (p[4*j+2] & p[4*j+1] & g[4*j])
                     | ((&p[4*j +: 3]) & gc[j]);
        end
    end

    assign sum   = p ^ c;
    assign c_out = gc[4];

endmodule

// File: rtl/pipelined_adder32.sv
// Two-stage 32-bit add/subtract pipeline with valid/ready flow control.
// Define PIPELINED_ADDER32_OVF_EN to add the registered signed-overflow output.
module pipelined_adder32 #(
    parameter int W = risc_alu_pkg::W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         c_in,
    input  logic         sub,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] sum,
    output logic         c_out
`ifdef PIPELINED_ADDER32_OVF_EN
    ,
    output logic         ovf
`endif
);
    import risc_alu_pkg::*;

    if (W != 32) begin : g_bad_width
        $error("pipelined_adder32: W must be 32");
    end

    // Handshake: a transfer happens on any rising edge where valid and ready
    // are both high; a producer holds valid and data until it transfers, and
    // in_ready never looks at in_valid.
    logic              s1_valid;
    s1_reg_t           s1_q;
    logic              s2_open;
    logic              s1_advance;
    logic [W-1:0]      b_eff;
    logic              c_eff;
    logic [HALF_W-1:0] lo_sum;
    logic              lo_carry;
    logic [HALF_W-1:0] hi_sum;
    logic              hi_carry;

    assign b_eff = sub ? ~b : b;
    assign c_eff = sub ? 1'b1 : c_in;

    assign s2_open    = !out_valid || out_ready;
    assign s1_advance = s1_valid && s2_open;
    assign in_ready   = !s1_valid || s1_advance;

    cla_adder16 u_cla_lo (
        .a     (a[HALF_W-1:0]),
        .b     (b_eff[HALF_W-1:0]),
        .c_in  (c_eff),
        .sum   (lo_sum),
        .c_out (lo_carry)
    );

    cla_adder16 u_cla_hi (
        .a     (s1_q.a_hi),
        .b     (s1_q.b_hi),
        .c_in  (s1_q.c_mid),
        .sum   (hi_sum),
        .c_out (hi_carry)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (in_ready) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_q.a_hi   <= a[W-1:HALF_W];
                s1_q.b_hi   <= b_eff[W-1:HALF_W];
                s1_q.sum_lo <= lo_sum;
                s1_q.c_mid  <= lo_carry;
            end
        end
    end

    // Stage 2 only reloads when its current result is gone or leaving.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out_valid <= 1'b0;
            sum       <= '0;
            c_out     <= 1'b0;
`ifdef PIPELINED_ADDER32_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (s2_open) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                sum   <= {hi_sum, s1_q.sum_lo};
                c_out <= hi_carry;
`ifdef PIPELINED_ADDER32_OVF_EN
                ovf   <= (s1_q.a_hi[HALF_W-1] == s1_q.b_hi[HALF_W-1])
                      && (hi_sum[HALF_W-1] != s1_q.a_hi[HALF_W-1]);
`endif
            end
        end
    end

endmodule

// File: tb/tb_pipelined_adder32.sv
// Directed self-checking bench for pipelined_adder32; overflow checks are
// compiled in when PIPELINED_ADDER32_OVF_EN is defined.
module tb_pipelined_adder32;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        c_in = 1'b0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] sum;
    logic        c_out;
`ifdef PIPELINED_ADDER32_OVF_EN
    logic        ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;
    logic [32:0] exp_q[$];

    pipelined_adder32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .c_in      (c_in),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .c_out     (c_out)
`ifdef PIPELINED_ADDER32_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    // Clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Driver: one operation with out_ready high; returns the observed result
    // and the number of edges until out_valid (0 if it never came).
    task automatic run_op(input logic [31:0] va, input logic [31:0] vb,
                          input logic vc, input logic vs,
                          output logic [31:0] s, output logic co,
                          output logic ov, output int lat);
        lat = 0;
        s   = '0;
        co  = 1'b0;
        ov  = 1'b0;
        @(negedge clk);
        a = va; b = vb; c_in = vc; sub = vs; in_valid = 1'b1; out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            in_valid = 1'b0;
            #1;
            if (out_valid) begin
                lat = i;
                s   = sum;
                co  = c_out;
`ifdef PIPELINED_ADDER32_OVF_EN
                ov  = ovf;
`endif
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || c_out !== 1'b0) begin
            n_err++;
            $display("FAIL reset_outputs: got v=%b sum=%h co=%b expected v=0 sum=0 co=0",
                     out_valid, sum, c_out);
        end
`ifdef PIPELINED_ADDER32_OVF_EN
        n_cmp++;
        if (ovf !== 1'b0) begin
            n_err++;
            $display("FAIL reset_ovf: got %b expected 0", ovf);
        end
`endif
        rst = 1'b1;
        @(negedge clk);
        #1;
        n_cmp++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_release: got in_ready=%b out_valid=%b expected 1/0",
                     in_ready, out_valid);
        end
    endtask

    task automatic test_carry_wrap();
        logic [31:0] s; logic co; logic ov; int lat;
        run_op(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, s, co, ov, lat);
        n_cmp++;
        if (lat !== 2) begin
            n_err++;
            $display("FAIL wrap_latency: got %0d expected 2", lat);
        end
        n_cmp++;
        if (s !== 32'h0 || co !== 1'b1) begin
            n_err++;
            $display("FAIL wrap_sum: got %h/%b expected 00000000/1", s, co);
        end
`ifdef PIPELINED_ADDER32_OVF_EN
        n_cmp++;
        if (ov !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_ovf: got %b expected 0", ov);
        end
`endif
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0) begin
            n_err++;
            $display("FAIL wrap_single: got out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_carry_in();
        logic [31:0] s; logic co; logic ov; int lat;
        run_op(32'h0000_FFFF, 32'h0, 1'b1, 1'b0, s, co, ov, lat);
        n_cmp++;
        if (lat !== 2 || s !== 32'h0001_0000 || co !== 1'b0) begin
            n_err++;
            $display("FAIL cin_mid: got lat=%0d %h/%b expected lat=2 00010000/0", lat, s, co);
        end
        run_op(32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, s, co, ov, lat);
        n_cmp++;
        if (lat !== 2 || s !== 32'h0 || co !== 1'b1) begin
            n_err++;
            $display("FAIL cin_wrap: got lat=%0d %h/%b expected lat=2 00000000/1", lat, s, co);
        end
    endtask

    task automatic test_overflow();
        logic [31:0] s; logic co; logic ov; int lat;
        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, s, co, ov, lat);
        n_cmp++;
        if (lat !== 2 || s !== 32'h8000_0000 || co !== 1'b0) begin
            n_err++;
            $display("FAIL ovf_sum: got lat=%0d %h/%b expected lat=2 80000000/0", lat, s, co);
        end
`ifdef PIPELINED_ADDER32_OVF_EN
        n_cmp++;
        if (ov !== 1'b1) begin
            n_err++;
            $display("FAIL ovf_flag: got %b expected 1", ov);
        end
`endif
    endtask

    task automatic test_subtract();
        logic [31:0] s; logic co; logic ov; int lat;
        run_op(32'h5, 32'h7, 1'b0, 1'b1, s, co, ov, lat);
        n_cmp++;
        if (lat !== 2 || s !== 32'hFFFF_FFFE || co !== 1'b0) begin
            n_err++;
            $display("FAIL sub_borrow: got lat=%0d %h/%b expected lat=2 fffffffe/0", lat, s, co);
        end
        run_op(32'h7, 32'h5, 1'b0, 1'b1, s, co, ov, lat);
        n_cmp++;
        if (s !== 32'h2 || co !== 1'b1) begin
            n_err++;
            $display("FAIL sub_plain: got %h/%b expected 00000002/1", s, co);
        end
        run_op(32'h7, 32'h5, 1'b1, 1'b1, s, co, ov, lat);
        n_cmp++;
        if (s !== 32'h2 || co !== 1'b1) begin
            n_err++;
            $display("FAIL sub_cin_ignored: got %h/%b expected 00000002/1", s, co);
        end
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, s, co, ov, lat);
        n_cmp++;
        if (s !== 32'h7FFF_FFFF || co !== 1'b1) begin
            n_err++;
            $display("FAIL sub_min: got %h/%b expected 7fffffff/1", s, co);
        end
`ifdef PIPELINED_ADDER32_OVF_EN
        n_cmp++;
        if (ov !== 1'b1) begin
            n_err++;
            $display("FAIL sub_min_ovf: got %b expected 1", ov);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [31:0] va [4];
        logic [31:0] vb [4];
        logic        vc [4];
        logic        vo [4];
        logic [32:0] got, want;
        va = '{32'h1, 32'h0000_FFFF, 32'h8000_0000, 32'h1234_5678};
        vb = '{32'h2, 32'h1,         32'h8000_0000, 32'h1111_1111};
        vc = '{1'b0, 1'b0, 1'b0, 1'b1};
        vo = '{1'b0, 1'b0, 1'b1, 1'b0};
        exp_q.push_back({1'b0, 32'h0000_0003});
        exp_q.push_back({1'b0, 32'h0001_0000});
        exp_q.push_back({1'b1, 32'h0000_0000});
        exp_q.push_back({1'b0, 32'h2345_678A});
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            out_ready = 1'b1;
            sub = 1'b0;
            if (k < 4) begin
                a = va[k]; b = vb[k]; c_in = vc[k]; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_err++;
                $display("FAIL b2b_in_ready[%0d]: got %b expected 1", k, in_ready);
            end
            if (k >= 2) begin
                want = exp_q.pop_front();
                got  = {c_out, sum};
                n_cmp++;
                if (out_valid !== 1'b1 || got !== want) begin
                    n_err++;
                    $display("FAIL b2b_result[%0d]: got v=%b %h expected v=1 %h",
                             k - 2, out_valid, got, want);
                end
`ifdef PIPELINED_ADDER32_OVF_EN
                n_cmp++;
                if (ovf !== vo[k-2]) begin
                    n_err++;
                    $display("FAIL b2b_ovf[%0d]: got %b expected %b", k - 2, ovf, vo[k-2]);
                end
`endif
            end
        end
        in_valid = 1'b0;
        c_in = 1'b0;
    endtask

    task automatic test_stall_stream();
        logic        pat [4];
        int          sent, got_n, cyc, occ;
        logic        prev_stall;
        logic [32:0] prev_word, want;
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        sent = 0; got_n = 0; cyc = 0; prev_stall = 1'b0; prev_word = '0;
        exp_q.delete();
        while (got_n < 10 && cyc < 200) begin
            @(negedge clk);
            occ       = sent - got_n;
            out_ready = pat[cyc % 4];
            sub       = 1'b0;
            c_in      = 1'b0;
            a         = 32'h0000_FFFF;
            b         = 32'(sent + 1);
            in_valid  = (sent < 10);
            #1;
            if (prev_stall) begin
                n_cmp++;
                if (out_valid !== 1'b1 || {c_out, sum} !== prev_word) begin
                    n_err++;
                    $display("FAIL stall_hold[cyc %0d]: got v=%b %h expected v=1 %h",
                             cyc, out_valid, {c_out, sum}, prev_word);
                end
            end
            if (occ == 2 && !out_ready) begin
                n_cmp++;
                if (in_ready !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_full_ready[cyc %0d]: got %b expected 0", cyc, in_ready);
                end
            end
            if (occ == 0) begin
                n_cmp++;
                if (in_ready !== 1'b1) begin
                    n_err++;
                    $display("FAIL stall_empty_ready[cyc %0d]: got %b expected 1", cyc, in_ready);
                end
            end
            if (out_valid && out_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_err++;
                    $display("FAIL stall_extra[cyc %0d]: got %h expected no result",
                             cyc, {c_out, sum});
                end else begin
                    want = exp_q.pop_front();
                    if ({c_out, sum} !== want) begin
                        n_err++;
                        $display("FAIL stall_result[%0d]: got %h expected %h",
                                 got_n, {c_out, sum}, want);
                    end
                end
                got_n++;
            end
            if (in_valid && in_ready) begin
                exp_q.push_back({1'b0, 32'h0001_0000 + 32'(sent)});
                sent++;
            end
            prev_stall = out_valid && !out_ready;
            prev_word  = {c_out, sum};
            cyc++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (got_n != 10 || exp_q.size() != 0) begin
            n_err++;
            $display("FAIL stall_count: got %0d results (%0d pending) expected 10 (0)",
                     got_n, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        out_ready = 1'b0; sub = 1'b0; c_in = 1'b0;
        a = 32'h1111_1111; b = 32'h2222_2222; in_valid = 1'b1;
        @(negedge clk);
        a = 32'h4444_4444; b = 32'h1; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0 || out_valid !== 1'b1 || sum !== 32'h3333_3333) begin
            n_err++;
            $display("FAIL rmid_full: got in_ready=%b v=%b sum=%h expected 0/1/33333333",
                     in_ready, out_valid, sum);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        n_cmp++;
        if (out_valid !== 1'b0 || sum !== 32'h0 || c_out !== 1'b0) begin
            n_err++;
            $display("FAIL rmid_cleared: got v=%b sum=%h co=%b expected 0/0/0",
                     out_valid, sum, c_out);
        end
        rst = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
                n_err++;
                $display("FAIL rmid_no_stale[%0d]: got in_ready=%b v=%b expected 1/0",
                         k, in_ready, out_valid);
            end
        end
    endtask

    initial begin
        test_reset();
        test_carry_wrap();
        test_carry_in();
        test_overflow();
        test_subtract();
        test_back_to_back();
        test_stall_stream();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
